jit_couple_seq: RTL

- Job sequencer for the accelerator coupling stage.
- Accepts one job command at a time. Each command carries a 6-bit routing configuration and a beat count.
- Drives the coupler's CONF bus and gates the operand streams (A, B) and the result stream (C) so that routing changes only happen between jobs, never mid-stream.
- Counts handshakes on each stream and reports completion.

---
 rtl/jit_couple_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/jit_couple_seq.sv
// Job sequencer: latches one command, settles CONF for a cycle, then gates A/B/C until N result beats (or abort).
// Latency N+2 cycles accept-to-done when streams flow freely; stalls only stretch RUN, commands wait while busy.
module jit_couple_seq #(
    parameter int LEN_W = 24
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        sCmd_tvalid,
    output logic        sCmd_tready,
    input  logic [31:0] sCmd_tdata,
    output logic [5:0]  CONF,
    output logic        gateA,
    output logic        gateB,
    output logic        gateC,
    input  logic        mA_tvalid,
    input  logic        mA_tready,
    input  logic        mB_tvalid,
    input  logic        mB_tready,
    input  logic        sC_tvalid,
    input  logic        sC_tready,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic               r_cmd_rdy;
    logic [5:0]         r_conf;
    logic               r_gate_a;
    logic               r_gate_b;
    logic               r_gate_c;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt_a;
    logic [LEN_W-1:0]   r_cnt_b;
    logic [LEN_W-1:0]   r_cnt_c;

    logic               w_beat_a;
    logic               w_beat_b;
    logic               w_beat_c;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_cnt_a_nx;
    logic [LEN_W-1:0]   w_cnt_b_nx;
    logic [LEN_W-1:0]   w_cnt_c_nx;
    logic               w_c_last;
    logic               w_unused_dat;

    // Handshakes only count while the stream is gated on; this is what prevents overrun past N.
    assign w_beat_a   = mA_tvalid & mA_tready & r_gate_a;
    assign w_beat_b   = mB_tvalid & mB_tready & r_gate_b;
    assign w_beat_c   = sC_tvalid & sC_tready & r_gate_c;
    assign w_cnt_a_nx = r_cnt_a + LEN_W'(w_beat_a);
    assign w_cnt_b_nx = r_cnt_b + LEN_W'(w_beat_b);
    assign w_cnt_c_nx = r_cnt_c + LEN_W'(w_beat_c);
    assign w_c_last   = (w_cnt_c_nx == r_len);

    assign w_len        = sCmd_tdata[8 +: LEN_W];
    assign w_unused_dat = ^sCmd_tdata;

    assign sCmd_tready = r_cmd_rdy;
    assign CONF        = r_conf;
    assign gateA       = r_gate_a;
    assign gateB       = r_gate_b;
    assign gateC       = r_gate_c;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= ST_IDLE;
            r_cmd_rdy <= 1'b0;
            r_conf    <= 6'b0;
            r_gate_a  <= 1'b0;
            r_gate_b  <= 1'b0;
            r_gate_c  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_len     <= '0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            r_cnt_c   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done   <= 1'b0;
                    r_gate_a <= 1'b0;
                    r_gate_b <= 1'b0;
                    r_gate_c <= 1'b0;
                    if (sCmd_tvalid && r_cmd_rdy) begin
                        r_cmd_rdy <= 1'b0;
                        r_err     <= 1'b0;
                        r_len     <= w_len;
                        r_cnt_a   <= '0;
                        r_cnt_b   <= '0;
                        r_cnt_c   <= '0;
                        if (w_len == '0) begin
                            // Empty job: report completion without touching the routing.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SETUP;
                            r_conf  <= sCmd_tdata[5:0];
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_cmd_rdy <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_state  <= ST_RUN;
                        r_gate_a <= 1'b1;
                        r_gate_b <= 1'b1;
                        r_gate_c <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cnt_a <= w_cnt_a_nx;
                    r_cnt_b <= w_cnt_b_nx;
                    r_cnt_c <= w_cnt_c_nx;
                    if (abort || w_c_last) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_err    <= abort;
                        r_gate_a <= 1'b0;
                        r_gate_b <= 1'b0;
                        r_gate_c <= 1'b0;
                    end else begin
                        r_gate_a <= (w_cnt_a_nx != r_len);
                        r_gate_b <= (w_cnt_b_nx != r_len);
                        r_gate_c <= (w_cnt_c_nx != r_len);
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_done    <= 1'b0;
                    r_cmd_rdy <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
